// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall vector layout, per-requester
// stall patterns, FSM state encodings and the priority merge of stall requests.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_bus_t;

  // Bit order: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
  localparam stall_bus_t STALL_NONE   = 6'b000000;
  localparam stall_bus_t STALL_BY_IF  = 6'b000011;
  localparam stall_bus_t STALL_BY_ID  = 6'b000111;
  localparam stall_bus_t STALL_BY_EX  = 6'b001111;
  localparam stall_bus_t STALL_BY_MEM = 6'b011111;

  typedef enum logic [1:0] {
    PIPE_RUN   = 2'd0,
    PIPE_PEND  = 2'd1,
    PIPE_FLUSH = 2'd2
  } pipe_state_e;

  function automatic stall_bus_t stall_merge(input logic if_req, input logic id_req,
                                             input logic ex_req, input logic mem_req);
    stall_bus_t v;
    if (mem_req)     v = STALL_BY_MEM;
    else if (ex_req) v = STALL_BY_EX;
    else if (id_req) v = STALL_BY_ID;
    else if (if_req) v = STALL_BY_IF;
    else             v = STALL_NONE;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall-cycle and redirect-pulse counters; compiled only when
// PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_any_i,
  input  logic        redirect_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_any_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_i && (flush_cnt_q != '1))  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, turns EX branches into PC redirect + flush,
// and replays a branch held back by a MEM stall. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if_i,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               stallreq_mem_i,
  input  logic               branch_flag_i,
  input  logic [31:0]        branch_target_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic               new_pc_valid_o,
  output logic [31:0]        new_pc_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  pipe_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [31:0]      last_pc_q;
  logic             last_vld_q;
  logic             redirect;
  logic             flush;
  logic             dup_branch;
  logic [31:0]      redirect_pc;
  stall_bus_t       stall_raw;

  // A branch repeating the target pulsed last cycle is a duplicate and is dropped.
  assign dup_branch = last_vld_q && (branch_target_i == last_pc_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_pc_d   = pend_pc_q;
    redirect    = 1'b0;
    flush       = 1'b0;
    redirect_pc = branch_target_i;
    case (state_q)
      PIPE_RUN, PIPE_FLUSH: begin
        flush = (state_q == PIPE_FLUSH);
        if (branch_flag_i && !dup_branch && !stallreq_mem_i) begin
          redirect = 1'b1;
        end else if (branch_flag_i && !dup_branch) begin
          pend_pc_d = branch_target_i;
          state_d   = PIPE_PEND;
        end else if ((state_q == PIPE_FLUSH) && !stallreq_mem_i) begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = '0;
            state_d = PIPE_RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      PIPE_PEND: begin
        if (!stallreq_mem_i) begin
          redirect    = 1'b1;
          redirect_pc = pend_pc_q;
          pend_pc_d   = '0;
        end
      end
      default: state_d = PIPE_RUN;
    endcase
    if (redirect) begin
      flush   = 1'b1;
      cnt_d   = CNT_LOAD;
      state_d = (CNT_LOAD != '0) ? PIPE_FLUSH : PIPE_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PIPE_RUN;
      cnt_q      <= '0;
      pend_pc_q  <= '0;
      last_vld_q <= 1'b0;
      last_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_pc_q  <= pend_pc_d;
      last_vld_q <= redirect;
      last_pc_q  <= redirect_pc;
    end
  end

  // IF/ID holds are dropped while flushing so the flushed slots become bubbles.
  assign stall_raw = stall_merge(stallreq_if_i & ~flush, stallreq_id_i & ~flush,
                                 stallreq_ex_i, stallreq_mem_i);

  assign stall_o        = rst ? STALL_NONE : stall_raw;
  assign flush_o        = flush & ~rst;
  assign new_pc_valid_o = redirect & ~rst;
  assign new_pc_o       = (redirect && !rst) ? redirect_pc : 32'd0;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_any_i (|stall_o),
    .redirect_i  (new_pc_valid_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (FLUSH_CYCLES=1 and 3) share stimulus,
// a cycle-level reference model queues expected outputs, a negedge monitor compares.
`timescale 1ns/1ps
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam int EXP_W = 104;
`else
  localparam int EXP_W = 40;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sr_if = 1'b0, sr_id = 1'b0, sr_ex = 1'b0, sr_mem = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;

  logic [5:0]  stall_w [2];
  logic        flush_w [2];
  logic        npv_w   [2];
  logic [31:0] npc_w   [2];
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] scnt_w  [2];
  logic [31:0] fcnt_w  [2];
`endif

  logic [EXP_W-1:0] exp_q0[$];
  logic [EXP_W-1:0] exp_q1[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) u_dut_f1 (
    .clk(clk), .rst(rst),
    .stallreq_if_i(sr_if), .stallreq_id_i(sr_id), .stallreq_ex_i(sr_ex), .stallreq_mem_i(sr_mem),
    .branch_flag_i(br), .branch_target_i(tgt),
    .stall_o(stall_w[0]), .flush_o(flush_w[0]), .new_pc_valid_o(npv_w[0]), .new_pc_o(npc_w[0])
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(scnt_w[0]), .flush_cnt_o(fcnt_w[0])
`endif
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) u_dut_f3 (
    .clk(clk), .rst(rst),
    .stallreq_if_i(sr_if), .stallreq_id_i(sr_id), .stallreq_ex_i(sr_ex), .stallreq_mem_i(sr_mem),
    .branch_flag_i(br), .branch_target_i(tgt),
    .stall_o(stall_w[1]), .flush_o(flush_w[1]), .new_pc_valid_o(npv_w[1]), .new_pc_o(npc_w[1])
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(scnt_w[1]), .flush_cnt_o(fcnt_w[1])
`endif
  );

  // Reference model: flush cycles still owed after the redirect cycle, a held branch,
  // and the last pulsed target; all state advances once per clock.
  int          fc_cfg [2] = '{1, 3};
  int          left_m [2];
  bit          pend_m [2];
  logic [31:0] pend_t_m [2];
  bit          last_m [2];
  logic [31:0] last_t_m [2];
  logic [31:0] scnt_m [2];
  logic [31:0] fcnt_m [2];

  function automatic logic [EXP_W-1:0] model_step(input int k, input logic r,
      input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
      input logic i_br, input logic [31:0] i_t);
    logic [5:0]  st;
    logic        fl, pv, take, pended, in_tail;
    logic [31:0] pc, tgt_use;
    logic [EXP_W-1:0] res;
    st = '0; fl = 1'b0; pv = 1'b0; pc = '0; take = 1'b0; pended = 1'b0; tgt_use = '0;
    if (r) begin
      left_m[k] = 0; pend_m[k] = 1'b0; last_m[k] = 1'b0;
      scnt_m[k] = '0; fcnt_m[k] = '0;
      res = '0;
      return res;
    end
    in_tail = (left_m[k] > 0);
    if (pend_m[k]) begin
      if (!i_mem) begin
        take = 1'b1; tgt_use = pend_t_m[k]; pend_m[k] = 1'b0;
      end
    end else if (i_br && !(last_m[k] && (i_t == last_t_m[k]))) begin
      if (!i_mem) begin
        take = 1'b1; tgt_use = i_t;
      end else begin
        pended = 1'b1; pend_m[k] = 1'b1; pend_t_m[k] = i_t;
      end
    end
    if (take) begin
      fl = 1'b1; pv = 1'b1; pc = tgt_use; left_m[k] = fc_cfg[k] - 1;
    end else if (pended) begin
      fl = in_tail; left_m[k] = 0;
    end else if (in_tail) begin
      fl = 1'b1;
      if (!i_mem) left_m[k] = left_m[k] - 1;
    end
    last_m[k] = take; last_t_m[k] = tgt_use;
    if (i_mem)              st = 6'b011111;
    else if (i_ex)          st = 6'b001111;
    else if (i_id && !fl)   st = 6'b000111;
    else if (i_if && !fl)   st = 6'b000011;
`ifdef PIPE_CTRL_PERF_EN
    res = {scnt_m[k], fcnt_m[k], st, fl, pv, pc};
    if ((st != 0) && (scnt_m[k] != 32'hFFFF_FFFF)) scnt_m[k] = scnt_m[k] + 1;
    if (pv && (fcnt_m[k] != 32'hFFFF_FFFF))        fcnt_m[k] = fcnt_m[k] + 1;
`else
    res = {st, fl, pv, pc};
`endif
    return res;
  endfunction

  task automatic cyc(input logic r, input logic i_if, input logic i_id, input logic i_ex,
                     input logic i_mem, input logic i_br, input logic [31:0] i_t);
    @(posedge clk);
    #1;
    rst = r; sr_if = i_if; sr_id = i_id; sr_ex = i_ex; sr_mem = i_mem; br = i_br; tgt = i_t;
    exp_q0.push_back(model_step(0, r, i_if, i_id, i_ex, i_mem, i_br, i_t));
    exp_q1.push_back(model_step(1, r, i_if, i_id, i_ex, i_mem, i_br, i_t));
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic cmp(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, got, want);
    end
  endtask

  task automatic check_dut(input int k, input logic [EXP_W-1:0] e);
    cmp("stall_o",        k, 32'(stall_w[k]), 32'(e[39:34]));
    cmp("flush_o",        k, 32'(flush_w[k]), 32'(e[33]));
    cmp("new_pc_valid_o", k, 32'(npv_w[k]),   32'(e[32]));
    cmp("new_pc_o",       k, npc_w[k],        e[31:0]);
`ifdef PIPE_CTRL_PERF_EN
    cmp("flush_cnt_o",    k, fcnt_w[k],       e[71:40]);
    cmp("stall_cnt_o",    k, scnt_w[k],       e[103:72]);
`endif
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q0.size() == 0) cmp("sb_empty", 0, 32'd0, 32'd1);
      else check_dut(0, exp_q0.pop_front());
      if (exp_q1.size() == 0) cmp("sb_empty", 1, 32'd0, 32'd1);
      else check_dut(1, exp_q1.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_tgt;
    logic [31:0] t;
    last_tgt = 32'h0000_1000;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    idle(2);
    // single-cycle ID hazard
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(1);
    // IF and MEM together
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    idle(1);
    // plain taken branch
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    idle(4);
    // branches during a 3-cycle MEM stall: first target is replayed
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00C0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(4);
    // MEM stall on the second flush cycle stretches the flush window
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(4);
    // branch alongside an EX busy stall
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    idle(4);
    // newer branch during flush, then a same-target repeat
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0340);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0340);
    idle(4);
    // reset while a branch is pending
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(3);
    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) t = last_tgt;
      else t = $urandom & 32'hFFFF_FFFC;
      last_tgt = t;
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), t);
    end
    idle(2);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    cmp("sb_drain", 0, 32'(exp_q0.size()), 32'd0);
    cmp("sb_drain", 1, 32'(exp_q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
